// File: rtl/stream_extremum_tracker_pkg.sv
// Shared state encodings and default widths for the stream extremum tracker.
package stream_extremum_tracker_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage : stream_extremum_tracker_pkg

// File: rtl/stream_extremum_tracker_cmp_select.sv
// Combinational two-input max/min selector; ties keep the running value i_a.
module cmp_select #(
    parameter int unsigned DATA_W   = 16,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          PICK_MAX = 1'b1
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y_c
);

    logic w_b_gt_a;
    logic w_b_lt_a;

    // Magnitude or two's-complement ordering of the candidate against the running value
    always_comb begin
        if (SIGNED) begin
            w_b_gt_a = $signed(i_b) > $signed(i_a);
            w_b_lt_a = $signed(i_b) < $signed(i_a);
        end else begin
            w_b_gt_a = i_b > i_a;
            w_b_lt_a = i_b < i_a;
        end
    end

    // Replace the running value only on a strict improvement
    always_comb begin
        o_y_c = i_a;
        if (PICK_MAX) begin
            if (w_b_gt_a) o_y_c = i_b;
        end else begin
            if (w_b_lt_a) o_y_c = i_b;
        end
    end

endmodule : cmp_select

// File: rtl/stream_extremum_tracker.sv
// Per-frame max/min/beat-count tracker on a valid/ready stream with a held result port.
module stream_extremum_tracker
    import stream_extremum_tracker_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_count
);

    state_t            r_state;
    logic [DATA_W-1:0] r_acc_max;
    logic [DATA_W-1:0] r_acc_min;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [DATA_W-1:0] r_out_max;
    logic [DATA_W-1:0] r_out_min;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_out_valid;
    logic              r_in_ready;

    logic              w_beat;
    logic [DATA_W-1:0] w_new_max;
    logic [DATA_W-1:0] w_new_min;
    logic [CNT_W-1:0]  w_new_cnt;

    assign w_beat = in_valid & r_in_ready;

    // Count stops at all-ones; extrema keep updating past saturation
    assign w_new_cnt = (r_acc_cnt == {CNT_W{1'b1}}) ? r_acc_cnt : r_acc_cnt + CNT_W'(1);

    cmp_select #(
        .DATA_W   (DATA_W),
        .SIGNED   (SIGNED),
        .PICK_MAX (1'b1)
    ) u_sel_max (
        .i_a   (r_acc_max),
        .i_b   (in_data),
        .o_y_c (w_new_max)
    );

    cmp_select #(
        .DATA_W   (DATA_W),
        .SIGNED   (SIGNED),
        .PICK_MAX (1'b0)
    ) u_sel_min (
        .i_a   (r_acc_min),
        .i_b   (in_data),
        .o_y_c (w_new_min)
    );

    // Frame FSM: accumulate beats, publish on last, hold result until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc_max   <= '0;
            r_acc_min   <= '0;
            r_acc_cnt   <= '0;
            r_out_max   <= '0;
            r_out_min   <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        r_acc_max <= in_data;
                        r_acc_min <= in_data;
                        r_acc_cnt <= CNT_W'(1);
                        if (in_last) begin
                            r_out_max   <= in_data;
                            r_out_min   <= in_data;
                            r_out_cnt   <= CNT_W'(1);
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_acc_max <= w_new_max;
                        r_acc_min <= w_new_min;
                        r_acc_cnt <= w_new_cnt;
                        if (in_last) begin
                            r_out_max   <= w_new_max;
                            r_out_min   <= w_new_min;
                            r_out_cnt   <= w_new_cnt;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;
    assign out_count = r_out_cnt;

endmodule : stream_extremum_tracker

// File: tb/tb_stream_extremum_tracker.sv
// Directed bench: three tracker variants (unsigned, signed, 2-bit count) share one stimulus stream.
module tb_stream_extremum_tracker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        u_in_ready, s_in_ready, c_in_ready;
    logic        u_out_valid, s_out_valid, c_out_valid;
    logic [15:0] u_max, u_min, s_max, s_min, c_max, c_min;
    logic [15:0] u_cnt, s_cnt;
    logic [1:0]  c_cnt;

    int n_checks;
    int n_pass;

    stream_extremum_tracker #(.DATA_W(16), .CNT_W(16), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_max(u_max), .out_min(u_min), .out_count(u_cnt)
    );

    stream_extremum_tracker #(.DATA_W(16), .CNT_W(16), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_max(s_max), .out_min(s_min), .out_count(s_cnt)
    );

    stream_extremum_tracker #(.DATA_W(16), .CNT_W(2), .SIGNED(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_max(c_max), .out_min(c_min), .out_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count, compare, report mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat, let it be taken at the next edge, sample 1 time unit later
    task automatic send_beat(input logic [15:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_valid", 32'(u_out_valid), 32'd0);
        chk("rst_max",   32'(u_max), 32'd0);
        chk("rst_min",   32'(u_min), 32'd0);
        chk("rst_cnt",   32'(u_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(u_in_ready), 32'd1);

        // Test 1: {10,20}
        send_beat(16'd10, 1'b0);
        chk("t1_mid_valid", 32'(u_out_valid), 32'd0);
        send_beat(16'd20, 1'b1);
        chk("t1_valid", 32'(u_out_valid), 32'd1);
        chk("t1_max",   32'(u_max), 32'd20);
        chk("t1_min",   32'(u_min), 32'd10);
        chk("t1_cnt",   32'(u_cnt), 32'd2);
        chk("t1_hold_ready", 32'(u_in_ready), 32'd0);
        step();
        chk("t1_valid_drop", 32'(u_out_valid), 32'd0);
        chk("t1_ready_back", 32'(u_in_ready), 32'd1);
        chk("t1_max_kept",   32'(u_max), 32'd20);

        // Test 2: {40,30,40,5} then {7}
        send_beat(16'd40, 1'b0);
        send_beat(16'd30, 1'b0);
        send_beat(16'd40, 1'b0);
        chk("t2_mid_valid", 32'(u_out_valid), 32'd0);
        send_beat(16'd5, 1'b1);
        chk("t2_valid", 32'(u_out_valid), 32'd1);
        chk("t2_max",   32'(u_max), 32'd40);
        chk("t2_min",   32'(u_min), 32'd5);
        chk("t2_cnt",   32'(u_cnt), 32'd4);
        step();
        send_beat(16'd7, 1'b1);
        chk("t2b_valid", 32'(u_out_valid), 32'd1);
        chk("t2b_max",   32'(u_max), 32'd7);
        chk("t2b_min",   32'(u_min), 32'd7);
        chk("t2b_cnt",   32'(u_cnt), 32'd1);
        step();

        // Test 3: {FFFF,0001} signed vs unsigned
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0001, 1'b1);
        chk("t3_u_max", 32'(u_max), 32'h0000FFFF);
        chk("t3_u_min", 32'(u_min), 32'h00000001);
        chk("t3_s_valid", 32'(s_out_valid), 32'd1);
        chk("t3_s_max", 32'(s_max), 32'h00000001);
        chk("t3_s_min", 32'(s_min), 32'h0000FFFF);
        chk("t3_s_cnt", 32'(s_cnt), 32'd2);
        step();

        // Test 4: back-pressure on {3,9}
        send_beat(16'd3, 1'b0);
        out_ready = 1'b0;
        send_beat(16'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(u_out_valid), 32'd1);
            chk("t4_hold_max",   32'(u_max), 32'd9);
            chk("t4_hold_min",   32'(u_min), 32'd3);
            chk("t4_hold_cnt",   32'(u_cnt), 32'd2);
            chk("t4_hold_ready", 32'(u_in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t4_release_valid", 32'(u_out_valid), 32'd0);
        chk("t4_release_ready", 32'(u_in_ready), 32'd1);

        // Test 5: reset mid-frame discards the partial frame
        send_beat(16'd100, 1'b0);
        send_beat(16'd200, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(u_out_valid), 32'd0);
        chk("t5_rst_max",   32'(u_max), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t5_idle_valid", 32'(u_out_valid), 32'd0);
        send_beat(16'd50, 1'b1);
        chk("t5_valid", 32'(u_out_valid), 32'd1);
        chk("t5_max",   32'(u_max), 32'd50);
        chk("t5_min",   32'(u_min), 32'd50);
        chk("t5_cnt",   32'(u_cnt), 32'd1);
        step();

        // Test 6: 2-bit count saturation on {1,2,3,4,0}
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b0);
        send_beat(16'd3, 1'b0);
        send_beat(16'd4, 1'b0);
        send_beat(16'd0, 1'b1);
        chk("t6_c_valid", 32'(c_out_valid), 32'd1);
        chk("t6_c_cnt",   32'(c_cnt), 32'd3);
        chk("t6_c_max",   32'(c_max), 32'd4);
        chk("t6_c_min",   32'(c_min), 32'd0);
        chk("t6_u_cnt",   32'(u_cnt), 32'd5);
        step();
        chk("t6_c_drop",  32'(c_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stream_extremum_tracker
